// File: rtl/rv_timer_lite_pkg.sv
// Shared register offsets, reset values and register-file type for the
// machine-timer peripheral.
package rv_timer_lite_pkg;

  localparam logic [7:0] TIMER_CTRL_OFFSET        = 8'h00;
  localparam logic [7:0] TIMER_PRESCALE_OFFSET    = 8'h04;
  localparam logic [7:0] TIMER_STEP_OFFSET        = 8'h08;
  localparam logic [7:0] TIMER_MTIME_LO_OFFSET    = 8'h10;
  localparam logic [7:0] TIMER_MTIME_HI_OFFSET    = 8'h14;
  localparam logic [7:0] TIMER_MTIMECMP_LO_OFFSET = 8'h18;
  localparam logic [7:0] TIMER_MTIMECMP_HI_OFFSET = 8'h1C;
  localparam logic [7:0] TIMER_INTR_ENABLE_OFFSET = 8'h20;
  localparam logic [7:0] TIMER_INTR_STATE_OFFSET  = 8'h24;
  localparam logic [7:0] TIMER_INTR_TEST_OFFSET   = 8'h28;

  localparam int unsigned TIMER_STEP_RST = 1;

  typedef struct packed {
    logic        active;
    logic        intr_enable;
    logic        intr_state;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
  } timer_regs_t;

  localparam timer_regs_t TIMER_REGS_RST = '{
    active:      1'b0,
    intr_enable: 1'b0,
    intr_state:  1'b0,
    mtime:       64'h0,
    mtimecmp:    {64{1'b1}}
  };

  // Merge a 32-bit write into an existing word, byte by byte.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rv_timer_lite_tick.sv
// Prescaled tick generator: counts 0..prescale while active and pulses
// tick on the terminal count.
module rv_timer_lite_tick #(
  parameter int PRESCALE_W = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_active,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_cnt;

  assign o_tick = i_active && (r_cnt == i_prescale);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_active || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/rv_timer_lite.sv
// Machine-timer peripheral: register decode, 64-bit mtime counter,
// mtimecmp compare and the level timer interrupt.
module rv_timer_lite
  import rv_timer_lite_pkg::*;
#(
  parameter int PRESCALE_W = 12,
  parameter int STEP_W     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        error_o,
  output logic        intr_timer_o
);

  timer_regs_t           r_regs;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [STEP_W-1:0]     r_step;

  logic [7:0]  w_addr;
  logic        w_unused_addr;
  logic        w_mapped;
  logic [31:0] w_rdata;
  logic        w_tick;
  logic        w_expired;
  logic        w_bit0;
  logic        w_mtime_wr;
  logic        w_prescale_wr;
  logic        w_intr_test_set;
  logic        w_intr_clear;

  assign w_addr        = {addr_i[7:2], 2'b00};
  assign w_unused_addr = ^addr_i[1:0];
  assign w_bit0        = wdata_i[0] & be_i[0];

  assign w_mtime_wr      = we_i && (w_addr == TIMER_MTIME_LO_OFFSET ||
                                    w_addr == TIMER_MTIME_HI_OFFSET);
  assign w_prescale_wr   = we_i && (w_addr == TIMER_PRESCALE_OFFSET);
  assign w_intr_test_set = we_i && (w_addr == TIMER_INTR_TEST_OFFSET) && w_bit0;
  assign w_intr_clear    = we_i && (w_addr == TIMER_INTR_STATE_OFFSET) && w_bit0;
  assign w_expired       = (r_regs.mtime >= r_regs.mtimecmp);

  rv_timer_lite_tick #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_active   (r_regs.active),
    .i_clr      (w_prescale_wr),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_mapped = 1'b1;
    w_rdata  = 32'h0;
    case (w_addr)
      TIMER_CTRL_OFFSET:        w_rdata = {31'h0, r_regs.active};
      TIMER_PRESCALE_OFFSET:    w_rdata = 32'(r_prescale);
      TIMER_STEP_OFFSET:        w_rdata = 32'(r_step);
      TIMER_MTIME_LO_OFFSET:    w_rdata = r_regs.mtime[31:0];
      TIMER_MTIME_HI_OFFSET:    w_rdata = r_regs.mtime[63:32];
      TIMER_MTIMECMP_LO_OFFSET: w_rdata = r_regs.mtimecmp[31:0];
      TIMER_MTIMECMP_HI_OFFSET: w_rdata = r_regs.mtimecmp[63:32];
      TIMER_INTR_ENABLE_OFFSET: w_rdata = {31'h0, r_regs.intr_enable};
      TIMER_INTR_STATE_OFFSET:  w_rdata = {31'h0, r_regs.intr_state};
      TIMER_INTR_TEST_OFFSET:   w_rdata = 32'h0;
      default:                  w_mapped = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_regs       <= TIMER_REGS_RST;
      r_prescale   <= '0;
      r_step       <= STEP_W'(TIMER_STEP_RST);
      rdata_o      <= 32'h0;
      error_o      <= 1'b0;
      intr_timer_o <= 1'b0;
    end else begin
      if (re_i) begin
        rdata_o <= w_mapped ? w_rdata : 32'h0;
        error_o <= ~w_mapped;
      end else if (we_i) begin
        rdata_o <= 32'h0;
        error_o <= ~w_mapped;
      end

      intr_timer_o <= r_regs.intr_state & r_regs.intr_enable;

      // A software mtime write suppresses the whole increment, carry included.
      if (w_tick && !w_mtime_wr) begin
        r_regs.mtime <= r_regs.mtime + 64'(r_step);
      end

      if (we_i) begin
        case (w_addr)
          TIMER_CTRL_OFFSET: begin
            if (be_i[0]) r_regs.active <= wdata_i[0];
          end
          TIMER_PRESCALE_OFFSET: begin
            for (int i = 0; i < PRESCALE_W; i++) begin
              if (be_i[i/8]) r_prescale[i] <= wdata_i[i];
            end
          end
          TIMER_STEP_OFFSET: begin
            for (int i = 0; i < STEP_W; i++) begin
              if (be_i[i/8]) r_step[i] <= wdata_i[i];
            end
          end
          TIMER_MTIME_LO_OFFSET:
            r_regs.mtime[31:0] <= apply_be(r_regs.mtime[31:0], wdata_i, be_i);
          TIMER_MTIME_HI_OFFSET:
            r_regs.mtime[63:32] <= apply_be(r_regs.mtime[63:32], wdata_i, be_i);
          TIMER_MTIMECMP_LO_OFFSET:
            r_regs.mtimecmp[31:0] <= apply_be(r_regs.mtimecmp[31:0], wdata_i, be_i);
          TIMER_MTIMECMP_HI_OFFSET:
            r_regs.mtimecmp[63:32] <= apply_be(r_regs.mtimecmp[63:32], wdata_i, be_i);
          TIMER_INTR_ENABLE_OFFSET: begin
            if (be_i[0]) r_regs.intr_enable <= wdata_i[0];
          end
          default: ;
        endcase
      end

      // Hardware set beats a same-cycle write-1-to-clear.
      if (w_expired || w_intr_test_set) begin
        r_regs.intr_state <= 1'b1;
      end else if (w_intr_clear) begin
        r_regs.intr_state <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_timer_lite.sv
// Self-checking bench for rv_timer_lite; expected values come from plain
// arithmetic on tick counts and a table of reset values.
module tb_rv_timer_lite;
  import rv_timer_lite_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        re_i;
  logic        we_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_o;
  logic        error_o;
  logic        intr_timer_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  rv_timer_lite dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .re_i         (re_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .be_i         (be_i),
    .rdata_o      (rdata_o),
    .error_o      (error_o),
    .intr_timer_o (intr_timer_o)
  );

  // All bus tasks start and end at a falling edge.
  task automatic wr_be(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    addr_i = a; wdata_i = d; be_i = be; we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0; be_i = 4'h0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_be(a, d, 4'hF);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic e);
    addr_i = a; re_i = 1'b1;
    @(negedge clk_i);
    re_i = 1'b0;
    d = rdata_o; e = error_o;
  endtask

  function automatic void exp_reset(input logic [7:0] a, output logic [31:0] d, output logic e);
    logic [7:0] w;
    w = {a[7:2], 2'b00};
    d = 32'h0; e = 1'b0;
    case (w)
      8'h00, 8'h04, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28: d = 32'h0;
      8'h08:        d = 32'h1;
      8'h18, 8'h1C: d = 32'hFFFF_FFFF;
      default:      e = 1'b1;
    endcase
  endfunction

  task automatic check_all_reset(input string tag);
    logic [31:0] d, ed;
    logic e, ee;
    logic [7:0] a;
    for (int i = 0; i <= 12; i++) begin
      a = (i == 12) ? 8'hFC : 8'(i * 4);
      rd(a, d, e);
      exp_reset(a, ed, ee);
      n_checks++;
      if (d !== ed || e !== ee) begin
        n_fail++;
        $display("FAIL %s addr=%h got data=%h err=%b exp data=%h err=%b", tag, a, d, e, ed, ee);
      end
    end
  endtask

  // Program the counter, run it, stop it and return the resulting mtime.
  task automatic run_count(input int p, input int step, input logic [63:0] start,
                           input int n, output logic [63:0] got);
    logic [31:0] lo, hi;
    logic e;
    wr(TIMER_PRESCALE_OFFSET, 32'(p));
    wr(TIMER_STEP_OFFSET, 32'(step));
    wr(TIMER_MTIME_LO_OFFSET, start[31:0]);
    wr(TIMER_MTIME_HI_OFFSET, start[63:32]);
    wr(TIMER_CTRL_OFFSET, 32'h1);
    repeat (n) @(negedge clk_i);
    wr(TIMER_CTRL_OFFSET, 32'h0);
    rd(TIMER_MTIME_LO_OFFSET, lo, e);
    rd(TIMER_MTIME_HI_OFFSET, hi, e);
    got = {hi, lo};
  endtask

  // Active for n+1 cycles; a tick lands on every (p+1)-th of them.
  function automatic logic [63:0] model_mtime(input int p, input int step,
                                              input logic [63:0] start, input int n);
    return start + 64'(step) * 64'((n + 1) / (p + 1));
  endfunction

  task automatic test_reset();
    logic [31:0] d, ed;
    logic e, ee;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    n_checks++;
    if (rdata_o !== 32'h0 || error_o !== 1'b0 || intr_timer_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdata=%h err=%b intr=%b exp 0/0/0", rdata_o, error_o, intr_timer_o);
    end
    check_all_reset("reset_read");
    rd(8'h13, d, e);
    exp_reset(8'h13, ed, ee);
    n_checks++;
    if (d !== ed || e !== ee) begin
      n_fail++;
      $display("FAIL addr_lsb_ignored got %h/%b exp %h/%b", d, e, ed, ee);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    logic e;
    wr_be(TIMER_MTIMECMP_LO_OFFSET, 32'hAABB_CCDD, 4'b0010);
    rd(TIMER_MTIMECMP_LO_OFFSET, d, e);
    n_checks++;
    if (d !== 32'hFFFF_CCFF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_enable got %h err=%b exp FFFFCCFF err=0", d, e);
    end
    wr(TIMER_MTIMECMP_LO_OFFSET, 32'hFFFF_FFFF);
    wr(8'h0C, 32'h1234_5678);
    n_checks++;
    if (error_o !== 1'b1 || rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL write_error got err=%b rdata=%h exp err=1 rdata=0", error_o, rdata_o);
    end
  endtask

  task automatic test_prescale();
    logic [63:0] got, exp;
    run_count(3, 1, 64'h0, 39, got);
    exp = model_mtime(3, 1, 64'h0, 39);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL prescale3 got %h exp %h", got, exp);
    end
    run_count(0, 1, 64'h0, 9, got);
    exp = model_mtime(0, 1, 64'h0, 9);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL prescale0 got %h exp %h", got, exp);
    end
  endtask

  task automatic test_carry();
    logic [63:0] got;
    run_count(0, 4, 64'h0000_0000_FFFF_FFFE, 0, got);
    n_checks++;
    if (got[63:32] !== 32'h1) begin
      n_fail++;
      $display("FAIL carry_hi got %h exp 00000001", got[63:32]);
    end
    n_checks++;
    if (got[31:0] !== 32'h2) begin
      n_fail++;
      $display("FAIL carry_lo got %h exp 00000002", got[31:0]);
    end
  endtask

  task automatic test_random();
    logic [63:0] start, got, exp;
    int p, step, n;
    for (int it = 0; it < 8; it++) begin
      p     = int'($urandom_range(0, 3));
      step  = int'($urandom_range(1, 255));
      n     = int'($urandom_range(0, 30));
      start = {32'($urandom_range(0, 32'hFFFF_FFF0)), 32'($urandom)};
      run_count(p, step, start, n, got);
      exp = model_mtime(p, step, start, n);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_count it=%0d p=%0d step=%0d n=%0d got %h exp %h", it, p, step, n, got, exp);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] lo, hi;
    logic e;
    wr(TIMER_PRESCALE_OFFSET, 32'h0);
    wr(TIMER_STEP_OFFSET, 32'h1);
    wr(TIMER_MTIME_LO_OFFSET, 32'hFFFF_FFFF);
    wr(TIMER_MTIME_HI_OFFSET, 32'h5);
    wr(TIMER_CTRL_OFFSET, 32'h1);
    wr(TIMER_MTIME_LO_OFFSET, 32'h1234);
    wr(TIMER_CTRL_OFFSET, 32'h0);
    rd(TIMER_MTIME_LO_OFFSET, lo, e);
    rd(TIMER_MTIME_HI_OFFSET, hi, e);
    n_checks++;
    if (lo !== 32'h1235 || hi !== 32'h5) begin
      n_fail++;
      $display("FAIL write_vs_tick got %h_%h exp 00000005_00001235", hi, lo);
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    logic e;
    int c;
    wr(TIMER_PRESCALE_OFFSET, 32'h0);
    wr(TIMER_STEP_OFFSET, 32'h1);
    wr(TIMER_MTIME_LO_OFFSET, 32'h0);
    wr(TIMER_MTIME_HI_OFFSET, 32'h0);
    wr(TIMER_MTIMECMP_LO_OFFSET, 32'd20);
    wr(TIMER_MTIMECMP_HI_OFFSET, 32'h0);
    wr(TIMER_INTR_ENABLE_OFFSET, 32'h1);
    wr(TIMER_INTR_STATE_OFFSET, 32'h1);
    @(negedge clk_i);
    n_checks++;
    if (intr_timer_o !== 1'b0) begin
      n_fail++;
      $display("FAIL intr_idle got %b exp 0", intr_timer_o);
    end
    wr(TIMER_CTRL_OFFSET, 32'h1);
    c = 0;
    while (intr_timer_o !== 1'b1 && c < 60) begin
      @(negedge clk_i);
      c++;
    end
    // mtime hits 20 after the 20th edge; two more edges to reach the pin.
    n_checks++;
    if (c !== 22) begin
      n_fail++;
      $display("FAIL intr_latency got %0d cycles exp 22", c);
    end
    wr(TIMER_INTR_STATE_OFFSET, 32'h1);
    rd(TIMER_INTR_STATE_OFFSET, d, e);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL intr_reset_after_w1c got %h exp 00000001", d);
    end
    wr(TIMER_CTRL_OFFSET, 32'h0);
    wr(TIMER_MTIMECMP_HI_OFFSET, 32'hFFFF_FFFF);
    wr(TIMER_MTIMECMP_LO_OFFSET, 32'hFFFF_FFFF);
    wr(TIMER_INTR_STATE_OFFSET, 32'h1);
    @(negedge clk_i);
    n_checks++;
    if (intr_timer_o !== 1'b0) begin
      n_fail++;
      $display("FAIL intr_quiet got %b exp 0", intr_timer_o);
    end
    rd(TIMER_INTR_STATE_OFFSET, d, e);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL intr_state_cleared got %h exp 00000000", d);
    end
  endtask

  task automatic test_intr_test();
    logic [31:0] d;
    logic e;
    wr(TIMER_INTR_ENABLE_OFFSET, 32'h0);
    wr(TIMER_INTR_TEST_OFFSET, 32'h1);
    rd(TIMER_INTR_STATE_OFFSET, d, e);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL intr_test_set got %h exp 00000001", d);
    end
    n_checks++;
    if (intr_timer_o !== 1'b0) begin
      n_fail++;
      $display("FAIL intr_masked got %b exp 0", intr_timer_o);
    end
    wr(TIMER_INTR_ENABLE_OFFSET, 32'h1);
    @(negedge clk_i);
    n_checks++;
    if (intr_timer_o !== 1'b1) begin
      n_fail++;
      $display("FAIL intr_enabled got %b exp 1", intr_timer_o);
    end
    rd(TIMER_INTR_TEST_OFFSET, d, e);
    n_checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL intr_test_read got %h err=%b exp 0 err=0", d, e);
    end
    wr(TIMER_INTR_STATE_OFFSET, 32'h1);
    rd(TIMER_INTR_STATE_OFFSET, d, e);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL intr_w1c got %h exp 00000000", d);
    end
  endtask

  task automatic test_reset_midcount();
    wr(TIMER_PRESCALE_OFFSET, 32'h2);
    wr(TIMER_STEP_OFFSET, 32'h7);
    wr(TIMER_INTR_ENABLE_OFFSET, 32'h1);
    wr(TIMER_MTIMECMP_LO_OFFSET, 32'h5);
    wr(TIMER_CTRL_OFFSET, 32'h1);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    addr_i = TIMER_MTIME_LO_OFFSET; wdata_i = 32'h55; be_i = 4'hF; we_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    n_checks++;
    if (rdata_o !== 32'h0 || error_o !== 1'b0 || intr_timer_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midcount_outputs got rdata=%h err=%b intr=%b exp 0/0/0", rdata_o, error_o, intr_timer_o);
    end
    check_all_reset("midcount_read");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; re_i = 1'b0; we_i = 1'b0;
    addr_i = 8'h0; wdata_i = 32'h0; be_i = 4'h0;
    @(negedge clk_i);
    test_reset();
    test_byte_enable();
    test_prescale();
    test_carry();
    test_random();
    test_same_cycle();
    test_interrupt();
    test_intr_test();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
